// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, select type and range helper for the register file.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int REGFILE_DEF_WIDTH    = 16;
  localparam int REGFILE_DEF_NUM_REGS = 8;
  localparam int REGFILE_MAX_RD       = 4;

  // Selects of any configured width are widened into this type before range
  // checks, so one helper serves every instance regardless of SEL_W.
  localparam int REGFILE_SEL_MAX_W = 32;
  typedef logic [REGFILE_SEL_MAX_W-1:0] regSel_t;

  // A select is usable only if it addresses an implemented register. This
  // matters when NUM_REGS is not a power of two and SEL_W can encode extras.
  function automatic logic sel_in_range(input regSel_t sel, input int unsigned numRegs);
    return (sel < numRegs);
  endfunction

endpackage

// File: rtl/regfile_param_if.sv
// regfile_param_if: read/write bus of the register file (decode reads, writeback writes).
// Latency: read outputs are combinational from selects; writes land on the rising clock edge.
// Backpressure: none; every write and read is accepted in its cycle.
//
// Ports (master = datapath, slave = register file):
//   read_sel   NUM_RD*SEL_W  packed read selects, port i at [i*SEL_W +: SEL_W]
//   write_sel  SEL_W         write register select
//   write_data WIDTH         write data
//   write_en   1             write enable
//   read_data  NUM_RD*WIDTH  packed read data, port i at [i*WIDTH +: WIDTH]
//   read_valid NUM_RD        selected register written since reset
//   err        1             error in the current cycle
//   err_sticky 1             latched error, cleared only by reset
interface regfile_param_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 2
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic [NUM_RD*SEL_W-1:0] read_sel;
  logic [SEL_W-1:0]        write_sel;
  logic [WIDTH-1:0]        write_data;
  logic                    write_en;
  logic [NUM_RD*WIDTH-1:0] read_data;
  logic [NUM_RD-1:0]       read_valid;
  logic                    err;
  logic                    err_sticky;

  modport master (
    output read_sel, write_sel, write_data, write_en,
    input  read_data, read_valid, err, err_sticky
  );

  modport slave (
    input  read_sel, write_sel, write_data, write_en,
    output read_data, read_valid, err, err_sticky
  );

endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port (mux, range check, optional write bypass).
// Latency: zero cycles, purely combinational.
// Backpressure: none.
//
// Ports: rdSel in, regArray/wrMark in (storage and scoreboard), rdData/rdValid/rdOob out.
// With REGFILE_BYPASS_EN defined, wrEn/wrSel/wrData are also inputs and a matching
// in-range write is forwarded to this port in the same cycle.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_DEF_WIDTH,
  parameter int NUM_REGS = REGFILE_DEF_NUM_REGS,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic [SEL_W-1:0]    rdSel,
  input  logic [WIDTH-1:0]    regArray [NUM_REGS],
  input  logic [NUM_REGS-1:0] wrMark,
`ifdef REGFILE_BYPASS_EN
  input  logic                wrEn,
  input  logic [SEL_W-1:0]    wrSel,
  input  logic [WIDTH-1:0]    wrData,
`endif
  output logic [WIDTH-1:0]    rdData,
  output logic                rdValid,
  output logic                rdOob
);

  always_comb begin
    rdData  = '0;
    rdValid = 1'b0;
    rdOob   = !sel_in_range(regSel_t'(rdSel), NUM_REGS);

    // Unimplemented indices read as an unwritten zero register.
    if (!rdOob) begin
      rdData  = regArray[rdSel];
      rdValid = wrMark[rdSel];
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the write that lands on this edge; deliberately not gated by
    // reset, so the reset cycle still shows the incoming write data.
    if (wrEn && sel_in_range(regSel_t'(wrSel), NUM_REGS) && (rdSel == wrSel)) begin
      rdData  = wrData;
      rdValid = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/regfile_param.sv
// regfile_param: NUM_REGS x WIDTH register file, NUM_RD read ports, written scoreboard, error flags.
// Latency: reads combinational; writes and scoreboard update on the rising edge of clk.
// Backpressure: none; out-of-range accesses are dropped and flagged on err/err_sticky.
//
// Ports: clk, rst (synchronous, active high), bus (regfile_param_if.slave; see interface).
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding per port).
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_DEF_WIDTH,
  parameter int NUM_REGS = REGFILE_DEF_NUM_REGS,
  parameter int NUM_RD   = 2
) (
  input  logic           clk,
  input  logic           rst,
  regfile_param_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_REGS);

  logic [WIDTH-1:0]    regArray [NUM_REGS];
  logic [NUM_REGS-1:0] wrMark;
  logic                writeInRange;
  logic                writeAccept;
  logic [NUM_RD-1:0]   rdOob;
  logic                xErr;

  assign writeInRange = sel_in_range(regSel_t'(bus.write_sel), NUM_REGS);
  assign writeAccept  = bus.write_en && writeInRange;

  // Storage and scoreboard; reset takes priority over a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regArray[i] <= '0;
      end
      wrMark <= '0;
    end else if (writeAccept) begin
      regArray[bus.write_sel] <= bus.write_data;
      wrMark[bus.write_sel]   <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRdPort
    regfile_rdport #(
      .WIDTH    (WIDTH),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
    ) uRdPort (
      .rdSel    (bus.read_sel[i*SEL_W +: SEL_W]),
      .regArray (regArray),
      .wrMark   (wrMark),
`ifdef REGFILE_BYPASS_EN
      .wrEn     (bus.write_en),
      .wrSel    (bus.write_sel),
      .wrData   (bus.write_data),
`endif
      .rdData   (bus.read_data[i*WIDTH +: WIDTH]),
      .rdValid  (bus.read_valid[i]),
      .rdOob    (rdOob[i])
    );
  end

  // An undriven or unknown write enable is a datapath bug worth flagging in
  // simulation; hardware has no X, so the term vanishes in synthesis.
  always_comb begin
    xErr = 1'b0;
`ifndef SYNTHESIS
    xErr = $isunknown(bus.write_en);
`endif
    bus.err = (bus.write_en && !writeInRange) || (|rdOob) || xErr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err_sticky <= 1'b0;
    end else begin
      bus.err_sticky <= bus.err_sticky | bus.err;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed and randomized checks of regfile_param in three configurations.
// Latency: stimulus applied 1 time unit after posedge, outputs sampled 2 units later.
// Backpressure: n/a.
module tb_regfile_param;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // dut0: default 16x8, 2 read ports
  logic        w0En;
  logic [2:0]  w0Sel;
  logic [15:0] w0Data;
  logic [2:0]  r0Sel [2];
  // dut1: 6 registers, 3-bit selects
  logic        w1En;
  logic [2:0]  w1Sel;
  logic [15:0] w1Data;
  logic [2:0]  r1Sel [2];
  // dut2: 32 bits wide, 3 read ports
  logic        w2En;
  logic [2:0]  w2Sel;
  logic [31:0] w2Data;
  logic [2:0]  r2Sel [3];

  regfile_param_if #(.WIDTH(16), .NUM_REGS(8), .NUM_RD(2)) bus0 ();
  regfile_param_if #(.WIDTH(16), .NUM_REGS(6), .NUM_RD(2)) bus1 ();
  regfile_param_if #(.WIDTH(32), .NUM_REGS(8), .NUM_RD(3)) bus2 ();

  assign bus0.write_en   = w0En;
  assign bus0.write_sel  = w0Sel;
  assign bus0.write_data = w0Data;
  assign bus0.read_sel   = {r0Sel[1], r0Sel[0]};
  assign bus1.write_en   = w1En;
  assign bus1.write_sel  = w1Sel;
  assign bus1.write_data = w1Data;
  assign bus1.read_sel   = {r1Sel[1], r1Sel[0]};
  assign bus2.write_en   = w2En;
  assign bus2.write_sel  = w2Sel;
  assign bus2.write_data = w2Data;
  assign bus2.read_sel   = {r2Sel[2], r2Sel[1], r2Sel[0]};

  regfile_param #(.WIDTH(16), .NUM_REGS(8), .NUM_RD(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  regfile_param #(.WIDTH(16), .NUM_REGS(6), .NUM_RD(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  regfile_param #(.WIDTH(32), .NUM_REGS(8), .NUM_RD(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      r0Sel[0] = 3'(r);
      r0Sel[1] = 3'(7 - r);
      #2;
      checks++;
      if (bus0.read_data !== 32'h0) begin
        failures++; $display("FAIL reset_data r%0d: got %h expected %h", r, bus0.read_data, 32'h0);
      end
      checks++;
      if (bus0.read_valid !== 2'b00) begin
        failures++; $display("FAIL reset_valid r%0d: got %b expected %b", r, bus0.read_valid, 2'b00);
      end
      checks++;
      if (bus0.err !== 1'b0 || bus0.err_sticky !== 1'b0) begin
        failures++; $display("FAIL reset_err r%0d: got %b/%b expected 0/0", r, bus0.err, bus0.err_sticky);
      end
      tick();
    end
    checks++;
    if (bus1.err_sticky !== 1'b0 || bus2.read_valid !== 3'b000) begin
      failures++; $display("FAIL reset_other: got sticky1=%b valid2=%b expected 0/000", bus1.err_sticky, bus2.read_valid);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] expD;
    w0En = 1'b1; w0Sel = 3'd3; w0Data = 16'hBEEF;
    r0Sel[0] = 3'd3; r0Sel[1] = 3'd3;
    #2;
    expD = BYPASS ? 16'hBEEF : 16'h0000;
    checks++;
    if (bus0.read_data !== {expD, expD}) begin
      failures++; $display("FAIL wr_same_cycle_data: got %h expected %h", bus0.read_data, {expD, expD});
    end
    checks++;
    if (bus0.read_valid !== {BYPASS, BYPASS}) begin
      failures++; $display("FAIL wr_same_cycle_valid: got %b expected %b", bus0.read_valid, {BYPASS, BYPASS});
    end
    tick();
    w0En = 1'b0; w0Data = 16'h0;
    #2;
    checks++;
    if (bus0.read_data !== 32'hBEEF_BEEF) begin
      failures++; $display("FAIL wr_next_cycle_data: got %h expected %h", bus0.read_data, 32'hBEEF_BEEF);
    end
    checks++;
    if (bus0.read_valid !== 2'b11) begin
      failures++; $display("FAIL wr_next_cycle_valid: got %b expected %b", bus0.read_valid, 2'b11);
    end
    tick();
  endtask

  task automatic test_reset_wins();
    logic [15:0] expD;
    rst = 1'b1; w0En = 1'b1; w0Sel = 3'd5; w0Data = 16'h1234;
    r0Sel[0] = 3'd5; r0Sel[1] = 3'd3;
    #2;
    expD = BYPASS ? 16'h1234 : 16'h0000;
    checks++;
    if (bus0.read_data !== {16'hBEEF, expD}) begin
      failures++; $display("FAIL rst_cycle_data: got %h expected %h", bus0.read_data, {16'hBEEF, expD});
    end
    tick();
    rst = 1'b0; w0En = 1'b0;
    #2;
    checks++;
    if (bus0.read_data !== 32'h0) begin
      failures++; $display("FAIL rst_wins_data: got %h expected %h", bus0.read_data, 32'h0);
    end
    checks++;
    if (bus0.read_valid !== 2'b00) begin
      failures++; $display("FAIL rst_wins_valid: got %b expected %b", bus0.read_valid, 2'b00);
    end
    tick();
  endtask

  task automatic test_write_disable();
    w0En = 1'b1; w0Sel = 3'd2; w0Data = 16'h1111;
    tick();
    w0En = 1'b0; w0Data = 16'h5555;
    r0Sel[0] = 3'd2; r0Sel[1] = 3'd2;
    #2;
    checks++;
    if (bus0.read_data !== 32'h1111_1111) begin
      failures++; $display("FAIL wen0_same_cycle: got %h expected %h", bus0.read_data, 32'h1111_1111);
    end
    tick();
    #2;
    checks++;
    if (bus0.read_data !== 32'h1111_1111 || bus0.read_valid !== 2'b11) begin
      failures++; $display("FAIL wen0_unchanged: got %h/%b expected %h/11", bus0.read_data, bus0.read_valid, 32'h1111_1111);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [15:0] expD;
    logic        expV;
    w1En = 1'b1; w1Sel = 3'd1; w1Data = 16'hAAAA;
    tick();
    w1Sel = 3'd5; w1Data = 16'h0055;
    tick();
    w1Sel = 3'd7; w1Data = 16'hFFFF;
    r1Sel[0] = 3'd1; r1Sel[1] = 3'd5;
    #2;
    checks++;
    if (bus1.err !== 1'b1 || bus1.err_sticky !== 1'b0) begin
      failures++; $display("FAIL oob_write_err: got err=%b sticky=%b expected 1/0", bus1.err, bus1.err_sticky);
    end
    checks++;
    if (bus1.read_data !== {16'h0055, 16'hAAAA} || bus1.read_valid !== 2'b11) begin
      failures++; $display("FAIL oob_write_reads: got %h/%b expected %h/11", bus1.read_data, bus1.read_valid, {16'h0055, 16'hAAAA});
    end
    tick();
    w1En = 1'b0;
    for (int r = 0; r < 6; r++) begin
      r1Sel[0] = 3'(r); r1Sel[1] = 3'(r);
      #2;
      expD = (r == 1) ? 16'hAAAA : ((r == 5) ? 16'h0055 : 16'h0000);
      expV = (r == 1) || (r == 5);
      checks++;
      if (bus1.read_data !== {expD, expD} || bus1.read_valid !== {expV, expV}) begin
        failures++; $display("FAIL oob_no_change r%0d: got %h/%b expected %h/%b", r, bus1.read_data, bus1.read_valid, {expD, expD}, {expV, expV});
      end
      checks++;
      if (bus1.err !== 1'b0 || bus1.err_sticky !== 1'b1) begin
        failures++; $display("FAIL oob_sticky r%0d: got err=%b sticky=%b expected 0/1", r, bus1.err, bus1.err_sticky);
      end
      tick();
    end
    r1Sel[0] = 3'd6; r1Sel[1] = 3'd7;
    #2;
    checks++;
    if (bus1.read_data !== 32'h0 || bus1.read_valid !== 2'b00) begin
      failures++; $display("FAIL oob_read_data: got %h/%b expected 0/00", bus1.read_data, bus1.read_valid);
    end
    checks++;
    if (bus1.err !== 1'b1) begin
      failures++; $display("FAIL oob_read_err: got %b expected 1", bus1.err);
    end
    tick();
    r1Sel[0] = 3'd0; r1Sel[1] = 3'd0;
  endtask

  task automatic test_wide_ports();
    logic [31:0] exp0, exp1, exp2;
    w2En = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w2Sel = 3'(i);
      w2Data = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    w2En = 1'b0;
    r2Sel[0] = 3'd0; r2Sel[1] = 3'd7; r2Sel[2] = 3'd7;
    #2;
    exp0 = 32'hA5A5_0000; exp1 = 32'hA5A5_0007; exp2 = 32'hA5A5_0007;
    checks++;
    if (bus2.read_data !== {exp2, exp1, exp0}) begin
      failures++; $display("FAIL wide_0_7_7: got %h expected %h", bus2.read_data, {exp2, exp1, exp0});
    end
    checks++;
    if (bus2.read_valid !== 3'b111 || bus2.err !== 1'b0) begin
      failures++; $display("FAIL wide_valid: got %b err=%b expected 111 err=0", bus2.read_valid, bus2.err);
    end
    tick();
    r2Sel[0] = 3'd4; r2Sel[1] = 3'd3; r2Sel[2] = 3'd4;
    #2;
    exp0 = 32'hA5A5_0004; exp1 = 32'hA5A5_0003;
    checks++;
    if (bus2.read_data !== {exp0, exp1, exp0}) begin
      failures++; $display("FAIL wide_4_3_4: got %h expected %h", bus2.read_data, {exp0, exp1, exp0});
    end
    tick();
  endtask

  // Reference model: plain arrays of register contents and written flags.
  task automatic test_random();
    logic [15:0] mReg  [8];
    bit          mMark [8];
    bit          mSticky;
    bit          xInj, wenX, wenOne, expErr, expV;
    logic [15:0] expD, gotD;
    int          s;

    rst = 1'b1; w0En = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mReg[i] = '0; mMark[i] = 1'b0;
    end
    mSticky = 1'b0;

    for (int c = 0; c < 10000; c++) begin
      rst    = ($urandom_range(63) == 0);
      xInj   = ($urandom_range(31) == 0);
      w0En   = xInj ? 1'bx : 1'($urandom_range(1));
      w0Sel  = 3'($urandom_range(7));
      w0Data = 16'($urandom);
      r0Sel[0] = 3'($urandom_range(7));
      r0Sel[1] = ($urandom_range(1) == 1) ? w0Sel : 3'($urandom_range(7));
      #2;
      wenX   = $isunknown(w0En);
      wenOne = (w0En === 1'b1);
      for (int p = 0; p < 2; p++) begin
        s    = int'(r0Sel[p]);
        expD = mReg[s];
        expV = mMark[s];
        if (BYPASS && wenOne && (s == int'(w0Sel))) begin
          expD = w0Data;
          expV = 1'b1;
        end
        gotD = bus0.read_data[p*16 +: 16];
        checks++;
        if (gotD !== expD || bus0.read_valid[p] !== expV) begin
          failures++;
          if (failures < 20) $display("FAIL rand_read c%0d p%0d: got %h/%b expected %h/%b", c, p, gotD, bus0.read_valid[p], expD, expV);
        end
      end
      expErr = wenX;
      checks++;
      if (bus0.err !== expErr || bus0.err_sticky !== mSticky) begin
        failures++;
        if (failures < 20) $display("FAIL rand_err c%0d: got %b/%b expected %b/%b", c, bus0.err, bus0.err_sticky, expErr, mSticky);
      end
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          mReg[i] = '0; mMark[i] = 1'b0;
        end
        mSticky = 1'b0;
      end else begin
        if (wenOne) begin
          mReg[w0Sel]  = w0Data;
          mMark[w0Sel] = 1'b1;
        end
        mSticky = mSticky | expErr;
      end
      tick();
    end
    rst = 1'b0; w0En = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    w0En = 1'b0; w0Sel = '0; w0Data = '0; r0Sel[0] = '0; r0Sel[1] = '0;
    w1En = 1'b0; w1Sel = '0; w1Data = '0; r1Sel[0] = '0; r1Sel[1] = '0;
    w2En = 1'b0; w2Sel = '0; w2Data = '0; r2Sel[0] = '0; r2Sel[1] = '0; r2Sel[2] = '0;
    tick();
    test_reset();
    test_write_read();
    test_reset_wins();
    test_write_disable();
    test_out_of_range();
    test_wide_ports();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
